// File: rtl/ldst_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ldst_sequencer
// Purpose : Runs one load/store at a time on the single-port 32-bit data
//           memory bus. Builds word-aligned cycles with byte enables,
//           extends load results for writeback, and stalls the pipeline
//           while an access is outstanding.
// Revision: 1.0 - initial release
// ============================================================================
module ldst_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_ldst_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_st_data,
  input  logic [3:0]        req_rd_index,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_byte_en,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [3:0]        wb_index,
  output logic [31:0]       wb_data,
  output logic              err_misalign,
  output logic              err_timeout
);

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  // Counter only needs to reach TIMEOUT-1; it saturates instead of wrapping.
  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LIM = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_off;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [3:0]          r_mem_be;
  logic [31:0]         r_mem_wdata;
  logic [3:0]          r_wb_index;
  logic [31:0]         r_wb_data;
  logic                r_err_mis;
  logic                r_err_to;

  logic [1:0]          w_off;
  logic [1:0]          w_size;
  logic                w_signed;
  logic                w_store;
  logic                w_misalign;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_lane;
  logic [31:0]         w_ext;

  // Decode the incoming request: size, alignment, lane enables, shifted data.
  always_comb begin
    w_off    = req_addr[1:0];
    w_store  = req_ldst_type[2] & (req_ldst_type[1] | req_ldst_type[0]);
    w_signed = (req_ldst_type == 3'd2) || (req_ldst_type == 3'd4);
    case (req_ldst_type)
      3'd0, 3'd5:       w_size = c_SZ_WORD;
      3'd1, 3'd2, 3'd6: w_size = c_SZ_HALF;
      default:          w_size = c_SZ_BYTE;
    endcase
    case (w_size)
      c_SZ_WORD: begin
        w_misalign = (w_off != 2'b00);
        w_be       = 4'b1111;
        w_wdata    = req_st_data;
      end
      c_SZ_HALF: begin
        w_misalign = w_off[0];
        w_be       = 4'b0011 << w_off;
        w_wdata    = {16'h0000, req_st_data[15:0]} << {w_off, 3'b000};
      end
      default: begin
        w_misalign = 1'b0;
        w_be       = 4'b0001 << w_off;
        w_wdata    = {24'h000000, req_st_data[7:0]} << {w_off, 3'b000};
      end
    endcase
  end

  // Bring the addressed lane(s) of the read word down to bit 0 and extend.
  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    case (r_size)
      c_SZ_WORD: w_ext = w_lane;
      c_SZ_HALF: w_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default:   w_ext = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
    endcase
  end

  // Sequencer FSM: accept, hold the bus cycle until ack or timeout, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_off       <= 2'b00;
      r_size      <= c_SZ_BYTE;
      r_signed    <= 1'b0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_wb_index  <= 4'h0;
      r_wb_data   <= 32'h0;
      r_err_mis   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_err_mis <= 1'b0;
      r_err_to  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_misalign) begin
              r_err_mis <= 1'b1;
            end else begin
              r_off       <= w_off;
              r_size      <= w_size;
              r_signed    <= w_signed;
              r_cnt       <= '0;
              r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              r_mem_we    <= w_store;
              r_mem_be    <= w_be;
              r_mem_wdata <= w_store ? w_wdata : 32'h0;
              r_wb_index  <= req_rd_index;
              r_state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (r_mem_we) begin
              r_state <= IDLE;
            end else begin
              r_wb_data <= w_ext;
              r_state   <= RESP;
            end
          end else if ((TIMEOUT > 0) && (r_cnt == c_CNT_LIM)) begin
            r_err_to <= 1'b1;
            r_state  <= IDLE;
          end else if (r_cnt != {c_CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign stall        = (r_state != IDLE);
  assign mem_req      = (r_state == ACCESS);
  assign mem_addr     = r_mem_addr;
  assign mem_we       = r_mem_we;
  assign mem_byte_en  = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign wb_valid     = (r_state == RESP);
  assign wb_index     = r_wb_index;
  assign wb_data      = r_wb_data;
  assign err_misalign = r_err_mis;
  assign err_timeout  = r_err_to;

endmodule
`default_nettype wire
